uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter (trmt/tx_data/tx_done handshake) among
//  NUM_REQ byte sources, e.g. cmd response and telemetry. Sources use req/ack.
//  Round-robin arbitration with frame locking: a source keeps the grant until
//  it sends a byte flagged last. Sits between the source blocks and the UART.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  DATA_W   8  byte width; must match the UART tx_data width
// PORTS
//  clk         in   1               system clock
//  rst_n       in   1               asynchronous active-low reset
//  req         in   NUM_REQ         per-source byte-valid; held until ack
//  req_data    in   NUM_REQ*DATA_W  source i byte in [i*DATA_W +: DATA_W]
//  req_last    in   NUM_REQ         byte is the final byte of its frame
//  ack         out  NUM_REQ         one-cycle pulse: byte accepted
//  trmt        out  1               one-cycle start pulse to the UART
//  tx_data     out  DATA_W          byte to the UART, stable trmt..tx_done
//  tx_done     in   1               UART level: high when idle after a byte
//  busy        out  1               high in LAUNCH or WAIT
//  lock        out  1               frame open: grant held by grant_id
//  grant_id    out  $clog2(NUM_REQ) index of the current/last granted source
// BEHAVIOUR
//  Reset: trmt=0, ack=0, tx_data=0, busy=0, lock=0, grant_id=0, rr_ptr=0, state=IDLE.
//  All outputs are registered.
//  FSM states: IDLE, LAUNCH, WAIT.
//  IDLE, lock=0:
//   - pick the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - no req: stay in IDLE.
//  IDLE, lock=1:
//   - only req[grant_id] is eligible; other reqs are ignored (no timeout).
//  On a pick, at the clock edge:
//   - tx_data<=req_data[i], grant_id<=i, last_q<=req_last[i], state<=LAUNCH.
//  LAUNCH (exactly 1 cycle):
//   - trmt=1 and ack[i]=1 in the same cycle.
//   - state<=WAIT.
//   - tx_done is not sampled here (the UART clears it on this edge).
//  WAIT:
//   - hold tx_data until tx_done=1 is sampled.
//   - then: last_q=1 -> lock<=0, rr_ptr<=grant_id+1 (wraps NUM_REQ-1 -> 0).
//   - last_q=0 -> lock<=1, rr_ptr unchanged.
//   - state<=IDLE.
//  Latency:
//   - req sampled high in IDLE at cycle t -> trmt/ack high in cycle t+1.
//   - next trmt no earlier than 2 cycles after tx_done is sampled high.
//  Source rule: after ack, deassert req or present the next byte the following
//  cycle. The FSM is in WAIT then, so no double-accept.
//  Pointer updates only at end of frame, so a locked frame is never interleaved.
//  Single-source case: back-to-back frames from the same source are allowed.
//  Changes to req/req_data during WAIT have no effect on tx_data.
//  Reset mid-frame: the FSM aborts to IDLE, lock clears, and no ack is replayed.
//  The UART is reset by the same rst_n.
// TESTING
//  1 Reset: all outputs 0. After release with req=0, 100 cycles -> trmt never pulses.
//  2 Single byte: req[2]=1, data 8'hA5, last=1.
//    -> trmt+ack[2] one cycle later, tx_data=8'hA5 held until tx_done.
//    -> grant_id=2, then rr_ptr=3.
//  3 Round-robin: req=4'b1111, each a 1-byte frame, held asserted.
//    -> grant order 0,1,2,3,0; each source acked exactly once per round.
//  4 Frame lock: src1 sends 3 bytes 11,22,33 (last on 33) while src0 and src3 request.
//    -> UART sees 11,22,33 contiguously, lock=1 between bytes, then src3 is granted.
//  5 Wrap: rr_ptr=3, req=4'b1001 -> src3 then src0.
//    A single requester with req held -> back-to-back frames,
//    and the trmt gap is >=2 cycles after tx_done.
//  6 Reset asserted in WAIT with lock=1.
//    -> outputs return to reset values asynchronously.
//    -> after release, the lowest-index req wins (rr_ptr=0).

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Source-side and UART-side handshake bundle for the shared transmitter arbiter.
// master = sources + UART model, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        ack;
  logic                      trmt;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;

  modport master (
    output req, req_data, req_last, tx_done,
    input  ack, trmt, tx_data
  );

  modport slave (
    input  req, req_data, req_last, tx_done,
    output ack, trmt, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// holding the grant for a whole frame until a byte flagged last is sent.

module uart_tx_arbiter_lane #(
  parameter  int NUM_REQ = 4,
  parameter  int IDX     = 0,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic            req,
  input  logic            lock,
  input  logic [ID_W-1:0] grant_id,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            elig,
  output logic            elig_hi
);
  localparam logic [ID_W-1:0] ME = ID_W'(IDX);

  // elig_hi marks candidates at or above the pointer; they beat wrapped ones
  always_comb begin
    elig    = req && (!lock || (grant_id == ME));
    elig_hi = elig && (ME >= rr_ptr);
  end
endmodule

module uart_tx_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic            busy,
  output logic            lock,
  output logic [ID_W-1:0] grant_id
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_e;

  state_e                         state_q, state_d;
  logic [NUM_REQ-1:0]             ack_q, ack_d;
  logic                           trmt_q, trmt_d;
  logic [DATA_W-1:0]              tx_data_q, tx_data_d;
  logic                           busy_q, busy_d;
  logic                           lock_q, lock_d;
  logic [ID_W-1:0]                grant_id_q, grant_id_d;
  logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic                           last_q, last_d;

  logic [NUM_REQ-1:0]             elig, elig_hi;
  logic                           pick_vld;
  logic [ID_W-1:0]                pick_idx;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_a;

  assign req_data_a = bus.req_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    uart_tx_arbiter_lane #(.NUM_REQ(NUM_REQ), .IDX(g)) u_lane (
      .req      (bus.req[g]),
      .lock     (lock_q),
      .grant_id (grant_id_q),
      .rr_ptr   (rr_ptr_q),
      .elig     (elig[g]),
      .elig_hi  (elig_hi[g])
    );
  end

  // Lowest eligible index overall, overridden by the lowest at/after rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_vld = 1'b1;
        pick_idx = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig_hi[i]) pick_idx = ID_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    lock_d     = lock_q;
    rr_ptr_d   = rr_ptr_q;
    trmt_d     = 1'b0;
    ack_d      = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          tx_data_d          = req_data_a[pick_idx];
          grant_id_d         = pick_idx;
          last_d             = bus.req_last[pick_idx];
          trmt_d             = 1'b1;
          ack_d[pick_idx]    = 1'b1;
          state_d            = LAUNCH;
        end
      end
      // tx_done is still the pre-launch idle level here; ignore it
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (bus.tx_done) begin
          state_d = IDLE;
          lock_d  = !last_q;
          if (last_q)
            rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      trmt_q     <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      lock_q     <= 1'b0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      trmt_q     <= trmt_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      lock_q     <= lock_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.trmt    = trmt_q;
  assign bus.tx_data = tx_data_q;
  assign busy        = busy_q;
  assign lock        = lock_q;
  assign grant_id    = grant_id_q;
endmodule
